// File: rtl/sha256_mem_responder.sv
// Memory-side partner of the SHA-256 core: host preload, start/done sequencing,
// single-cycle registered core memory port and a valid/ready dump of the 8 hash words.
module sha256_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter logic [15:0] MSG_ADDR = 16'h0000,
  parameter logic [15:0] OUT_ADDR = 16'h0080,
  parameter int          TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic        go,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        hash_valid,
  input  logic        hash_ready,
  output logic [31:0] hash_data,
  output logic        hash_last,
  output logic        busy,
  output logic        err,
  output logic [31:0] run_cycles
);
  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_LOW, S_WAIT_DONE, S_DUMP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            hash_valid_q, hash_valid_d;
  logic [31:0]     hash_data_q, hash_data_d;
  logic            hash_last_q, hash_last_d;
  logic            err_q, err_d;
  logic [31:0]     run_cycles_q, run_cycles_d;
  logic [31:0]     mem_q [DEPTH];

  logic            core_ok, host_ok, host_wr, core_wr, fetch;
  logic [AW-1:0]   core_idx, host_idx, out_base;
  logic [2:0]      fetch_idx;
  logic [31:0]     cnt_inc;

  assign core_ok  = {1'b0, mem_addr} < DEPTH_W;
  assign host_ok  = {1'b0, host_addr} < DEPTH_W;
  assign core_idx = mem_addr[AW-1:0];
  assign host_idx = host_addr[AW-1:0];
  assign out_base = OUT_ADDR[AW-1:0];
  assign host_wr  = (state_q == S_IDLE) && host_we && host_ok;
  assign core_wr  = mem_we && core_ok;

  // Core write follows the host write so the core wins a same-address collision.
  always_ff @(posedge clk) begin
    if (host_wr) mem_q[host_idx] <= host_wdata;
    if (core_wr) mem_q[core_idx] <= mem_write_data;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rdata_d      = core_ok ? mem_q[core_idx] : 32'h0;
    hash_valid_d = hash_valid_q;
    hash_data_d  = hash_data_q;
    hash_last_d  = hash_last_q;
    err_d        = err_q;
    run_cycles_d = run_cycles_q;
    cnt_inc      = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q : run_cycles_q + 32'd1;
    fetch        = 1'b0;
    fetch_idx    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          err_d        = 1'b0;
          run_cycles_d = 32'h0;
          state_d      = S_START;
        end
      end
      S_START: state_d = S_WAIT_LOW;
      S_WAIT_LOW: begin
        run_cycles_d = cnt_inc;
        if (cnt_inc >= TIMEOUT_W) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!done) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        run_cycles_d = cnt_inc;
        if (cnt_inc >= TIMEOUT_W) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (done) begin
          state_d   = S_DUMP;
          idx_d     = 3'd0;
          fetch     = 1'b1;
          fetch_idx = 3'd0;
        end
      end
      S_DUMP: begin
        // A handshake leaves one empty cycle in which the next word is fetched.
        if (hash_valid_q) begin
          if (hash_ready) begin
            hash_valid_d = 1'b0;
            hash_last_d  = 1'b0;
            if (idx_q == 3'd7) state_d = S_IDLE;
            else               idx_d   = idx_q + 3'd1;
          end
        end else begin
          fetch = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fetch) begin
      hash_data_d  = mem_q[out_base + AW'(fetch_idx)];
      hash_valid_d = 1'b1;
      hash_last_d  = (fetch_idx == 3'd7);
    end
    if (!core_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      rdata_q      <= 32'h0;
      hash_valid_q <= 1'b0;
      hash_data_q  <= 32'h0;
      hash_last_q  <= 1'b0;
      err_q        <= 1'b0;
      run_cycles_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rdata_q      <= rdata_d;
      hash_valid_q <= hash_valid_d;
      hash_data_q  <= hash_data_d;
      hash_last_q  <= hash_last_d;
      err_q        <= err_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign start         = (state_q == S_START);
  assign busy          = (state_q != S_IDLE);
  assign message_addr  = MSG_ADDR;
  assign output_addr   = OUT_ADDR;
  assign mem_read_data = rdata_q;
  assign hash_valid    = hash_valid_q;
  assign hash_data     = hash_data_q;
  assign hash_last     = hash_last_q;
  assign err           = err_q;
  assign run_cycles    = run_cycles_q;
endmodule

// File: tb/tb_sha256_mem_responder.sv
// Randomized bench for sha256_mem_responder: reference memory array, read and hash
// scoreboards checked by a monitor on the falling edge.
module tb_sha256_mem_responder;
  localparam int DEPTH    = 256;
  localparam int OUT_ADDR = 128;
  localparam int TIMEOUT  = 4096;

  logic        clk, reset_n, host_we, go, done, mem_we;
  logic        hash_ready = 1'b0;
  logic [15:0] host_addr, mem_addr;
  logic [31:0] host_wdata, mem_write_data;
  logic        start, hash_valid, hash_last, busy, err;
  logic [15:0] message_addr, output_addr;
  logic [31:0] mem_read_data, hash_data, run_cycles;

  sha256_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .go(go), .start(start), .message_addr(message_addr),
    .output_addr(output_addr), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_data(hash_data),
    .hash_last(hash_last), .busy(busy), .err(err), .run_cycles(run_cycles)
  );

  typedef struct { int stamp; logic [31:0] dat; } rd_t;
  typedef struct { logic [31:0] dat; logic last; } hw_t;

  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  logic [31:0] ref_mem [DEPTH];
  rd_t         rd_q[$];
  hw_t         hq[$];
  bit          m_idle = 1'b1;
  bit          rd_chk = 1'b0;
  bit          stall_arm = 1'b0;
  int          stall_cnt = 0;
  int          words_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [15:0] a);
    return a < 16'(DEPTH);
  endfunction

  // One clock with the current inputs; reference memory commits what the DUT should commit.
  task automatic step();
    logic [31:0] e;
    if (reset_n) begin
      if (rd_chk) begin
        e = in_rng(mem_addr) ? ref_mem[mem_addr[7:0]] : 32'h0;
        rd_q.push_back('{cyc_n, e});
      end
      if (m_idle && host_we && in_rng(host_addr)) ref_mem[host_addr[7:0]] = host_wdata;
      if (mem_we && in_rng(mem_addr)) ref_mem[mem_addr[7:0]] = mem_write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_go(input bit with_write);
    go = 1'b1;
    host_we = with_write;
    host_addr = 16'd10;
    host_wdata = $urandom;
    words_seen = 0;
    step();
    go = 1'b0;
    host_we = 1'b0;
    m_idle = 1'b0;
    check("start_pulse", {31'h0, start}, 32'd1);
    check("busy_entry", {31'h0, busy}, 32'd1);
    check("err_clear", {31'h0, err}, 32'd0);
  endtask

  // Core model: done low from the start cycle for k cycles, hash words written early.
  task automatic core_phase(input int k, input bit fixed);
    done = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (i < 8) begin
        mem_we = 1'b1;
        mem_addr = 16'(OUT_ADDR + i);
        mem_write_data = fixed ? 32'h1111_1111 * 32'(i + 1) : $urandom;
      end else begin
        mem_we = 1'($urandom % 2);
        mem_addr = 16'($urandom_range(0, OUT_ADDR - 1));
        mem_write_data = $urandom;
      end
      go = (i >= 20 && i < 23);
      host_we = (i >= 20 && i < 23);
      host_addr = 16'd20;
      host_wdata = 32'hBADC_0DE0 + 32'(i);
      step();
      if (i == 0) check("start_once", {31'h0, start}, 32'd0);
    end
    mem_we = 1'b0;
    go = 1'b0;
    host_we = 1'b0;
    done = 1'b1;
    for (int j = 0; j < 8; j++) hq.push_back('{ref_mem[OUT_ADDR + j], j == 7});
    step();
    check("dump_valid", {31'h0, hash_valid}, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      mem_addr = 16'($urandom_range(0, DEPTH - 1));
      step();
      n++;
    end
    check("idle_bound", {31'h0, busy}, 32'd0);
    m_idle = 1'b1;
  endtask

  task automatic full_run(input int k, input bit fixed, input bit wr);
    issue_go(wr);
    core_phase(k, fixed);
    wait_idle(300);
    check("hash_count", 32'(hq.size()), 32'd0);
    check("words_seen", 32'(words_seen), 32'd8);
    // Cycles spent waiting: START cycle excluded, the cycle that sees done high included.
    check("run_cycles", run_cycles, 32'(k));
    check("run_err", {31'h0, err}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        hash_ready = 1'b0;
        stall_cnt--;
      end else if (stall_arm && words_seen == 2 && hash_valid) begin
        stall_arm = 1'b0;
        stall_cnt = 9;
        hash_ready = 1'b0;
      end else begin
        hash_ready = 1'($urandom % 2);
      end
    end
  end

  initial begin
    rd_t r;
    hw_t h;
    bit gap_chk = 0, busy_chk = 0, hold_chk = 0;
    logic [31:0] hold_dat = 32'h0;
    forever begin
      @(negedge clk);
      if (rd_q.size() > 0 && rd_q[0].stamp < cyc_n) begin
        r = rd_q.pop_front();
        check("rd_data", mem_read_data, r.dat);
      end
      if (reset_n) begin
        if (gap_chk) check("hash_gap", {31'h0, hash_valid}, 32'd0);
        if (busy_chk) check("busy_drop", {31'h0, busy}, 32'd0);
        if (hold_chk) check("hash_hold", hash_valid ? hash_data : 32'hxxxx_xxxx, hold_dat);
        gap_chk = 0;
        busy_chk = 0;
        hold_chk = 0;
        if (hash_valid && hq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL hash_extra: got valid word %h expected no word", hash_data);
        end else if (hash_valid && hash_ready) begin
          h = hq.pop_front();
          check("hash_data", hash_data, h.dat);
          check("hash_last", {31'h0, hash_last}, {31'h0, h.last});
          words_seen++;
          gap_chk = 1;
          busy_chk = h.last;
        end else if (hash_valid) begin
          hold_chk = 1;
          hold_dat = hash_data;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] old;
    int n;
    reset_n = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 32'h0; go = 1'b0;
    done = 1'b1; mem_we = 1'b0; mem_addr = 16'd5; mem_write_data = 32'h0;
    step();
    step();
    check("rst_start", {31'h0, start}, 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    check("rst_valid", {31'h0, hash_valid}, 32'd0);
    check("rst_hdata", hash_data, 32'd0);
    check("rst_last", {31'h0, hash_last}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_cycles", run_cycles, 32'd0);
    check("msg_addr", {16'h0, message_addr}, 32'h0000);
    check("out_addr", {16'h0, output_addr}, 32'h0080);

    reset_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      host_we = 1'b1; host_addr = 16'(a); host_wdata = $urandom;
      step();
    end
    mem_addr = 16'd0;
    rd_chk = 1'b1;
    host_addr = 16'd5; host_wdata = 32'hDEAD_BEEF;
    step();
    host_we = 1'b0; mem_addr = 16'd5;
    step();
    check("rt_read", mem_read_data, 32'hDEAD_BEEF);
    old = ref_mem[9];
    mem_we = 1'b1; mem_addr = 16'd9; mem_write_data = 32'hCAFE_F00D;
    step();
    check("rw_old", mem_read_data, old);
    mem_we = 1'b0;
    step();
    check("rw_new", mem_read_data, 32'hCAFE_F00D);
    for (int i = 0; i < 40; i++) begin
      mem_we = 1'($urandom % 2);
      mem_addr = 16'($urandom_range(0, DEPTH - 1));
      mem_write_data = $urandom;
      step();
    end
    mem_we = 1'b0;

    stall_arm = 1'b1;
    full_run(100, 1'b1, 1'b1);
    full_run($urandom_range(30, 90), 1'b0, 1'b0);
    mem_addr = 16'd10; step();
    mem_addr = 16'd20; step();

    mem_addr = 16'(DEPTH);
    step();
    check("oor_read", mem_read_data, 32'd0);
    check("oor_err", {31'h0, err}, 32'd1);
    mem_we = 1'b1; mem_addr = 16'(DEPTH + 3); mem_write_data = ~ref_mem[3];
    step();
    mem_we = 1'b0; mem_addr = 16'd3;
    step();
    check("oor_nowrite", mem_read_data, ref_mem[3]);
    full_run($urandom_range(30, 90), 1'b0, 1'b0);

    issue_go(1'b0);
    core_phase($urandom_range(30, 60), 1'b0);
    n = 0;
    while (!(words_seen == 4 && hash_valid) && n < 200) begin
      mem_addr = 16'($urandom_range(0, DEPTH - 1));
      step();
      n++;
    end
    check("reach_word4", 32'(words_seen), 32'd4);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    hq.delete();
    m_idle = 1'b1;
    check("rr_busy", {31'h0, busy}, 32'd0);
    check("rr_valid", {31'h0, hash_valid}, 32'd0);
    check("rr_start", {31'h0, start}, 32'd0);

    issue_go(1'b0);
    n = 0;
    while (busy && n < TIMEOUT + 20) begin
      mem_addr = 16'($urandom_range(0, DEPTH - 1));
      step();
      n++;
    end
    m_idle = 1'b1;
    check("to_len", 32'(n), 32'(TIMEOUT + 1));
    check("to_busy", {31'h0, busy}, 32'd0);
    check("to_err", {31'h0, err}, 32'd1);
    check("to_cycles", run_cycles, 32'(TIMEOUT));
    check("to_valid", {31'h0, hash_valid}, 32'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha256_mem_responder.md
# sha256_mem_responder

Memory-side partner of the SHA-256 core: owns the word-addressed message/hash memory the core reads and writes through its memory port. A host preloads message words, then issues `go`. The block pulses `start`, serves the core's reads and writes with one-cycle registered read latency, and waits for `done`. It then streams the eight hash words out over a valid/ready port. It sits between the testbench/host and the hash core, and also serves as the reference memory model for core verification.

## Interface
- DEPTH, 256: memory depth in 32-bit words; legal addresses 0..DEPTH-1.
- MSG_ADDR, 16'h0000: value driven on `message_addr`.
- OUT_ADDR, 16'h0080: value driven on `output_addr`; base of the 8-word hash dump.
- TIMEOUT, 4096: maximum cycles in WAIT_LOW plus WAIT_DONE before abort.
- clk  in  1  single clock; the core's `mem_clk` is this same clock.
- reset_n  in  1  synchronous, active-low reset.
- host_we  in  1  host write strobe; honoured only in IDLE.
- host_addr  in  16  host write word address.
- host_wdata  in  32  host write data.
- go  in  1  start a run; honoured only in IDLE.
- start  out  1  one-cycle start pulse to the core.
- message_addr  out  16  constant MSG_ADDR.
- output_addr  out  16  constant OUT_ADDR.
- done  in  1  core done; level, high while the core is idle.
- mem_we  in  1  core write enable.
- mem_addr  in  16  core word address.
- mem_write_data  in  32  core write data.
- mem_read_data  out  32  registered read data to the core.
- hash_valid  out  1  hash word available.
- hash_ready  in  1  consumer accepts the hash word.
- hash_data  out  32  hash word; h0 first.
- hash_last  out  1  high with the 8th word.
- busy  out  1  state != IDLE.
- err  out  1  sticky error: out-of-range access or timeout.
- run_cycles  out  32  cycle count of the last run.

## Operation
- **States:** IDLE, START, WAIT_LOW, WAIT_DONE, DUMP.
- **IDLE**
  - A host write with `host_addr < DEPTH` commits at the edge.
  - On `go`: clear `err` and `run_cycles`, then go to START.
  - `go` and `host_we` in the same cycle: the write commits and the run starts.
- **START:** `start`=1 for exactly this cycle, then go to WAIT_LOW.
- **WAIT_LOW:** on `done`=0, go to WAIT_DONE.
- **WAIT_DONE:** on `done`=1, go to DUMP.
- **Cycle count:** `run_cycles` increments every cycle spent in WAIT_LOW or WAIT_DONE. It is frozen elsewhere and saturates at all-ones.
- **Timeout:** when the combined cycle count in WAIT_LOW and WAIT_DONE reaches TIMEOUT, set `err` and return to IDLE with no dump.
- **Core port (serviced in every state)**
  - Write: `mem_we`=1 with in-range `mem_addr` commits at the edge.
  - Read: `mem_read_data` is updated every edge to mem[`mem_addr`] as sampled at that edge.
  - Same-address read and write in one cycle returns the old data.
  - Out of range (`mem_addr` >= DEPTH): the read returns 0, the write is dropped, and `err` is set.
- **DUMP**
  - An internal index runs 0..7 over addresses OUT_ADDR+idx, using the registered read port.
  - On a handshake (`hash_valid` && `hash_ready`), advance idx. After the idx=7 handshake, return to IDLE.
  - `hash_data` stays stable while `hash_valid` && !`hash_ready`.
- **Ignored inputs:** `go` and `host_we` outside IDLE have no effect.
- **Memory contents:** not reset.

## Timing
- **Reset values:** `start`, `mem_read_data`, `hash_valid`, `hash_data`, `hash_last`, `err`, `busy` and `run_cycles` are all 0. State is IDLE.
- **Reset mid-run:** returns to IDLE next cycle with `start`=0; any dump in progress is abandoned.
- **Run entry:** `go` sampled at edge N gives `start`=1 in cycle N+1 and `busy`=1 from N+1.
- **Read latency:** 1 cycle. The address presented in cycle T produces data valid in cycle T+1.
- **Dump cadence**
  - On entry to DUMP at edge E, the read of word 0 is issued. `hash_valid`=1 from cycle E+1.
  - After each handshake, `hash_valid`=0 for exactly one cycle while the next word is fetched. Peak rate is 1 word per 2 cycles.
  - `hash_last`=1 only with word 7. `busy` drops the cycle after the final handshake.
- **Back-to-back runs:** `go` is honoured on the first IDLE cycle after a dump.

## Test plan
- **Write/read round trip:** reset; host writes 0xDEADBEEF to address 5 in IDLE; core port presents `mem_addr`=5 at cycle T -> `mem_read_data`=0xDEADBEEF at T+1; 0 before, as the reset value.
- **Run handshake:** `go` at edge N -> `start` high only in N+1. Model the core with `done` low for 100 cycles, writing 0x11111111..0x88888888 to OUT_ADDR..OUT_ADDR+7 -> `run_cycles`=100. Dump order is 0x11111111..0x88888888, `hash_last` only on 0x88888888.
- **Back-pressure:** `hash_ready` held 0 for 10 cycles during word 2 -> `hash_data` stable, no word skipped or duplicated.
- **Out of range:** core reads `mem_addr`=DEPTH -> `mem_read_data`=0 and `err`=1. Core writes DEPTH+3 -> no memory change. A later `go` clears `err`.
- **Timeout:** `done` held high after `start` -> after TIMEOUT cycles, `err`=1, `busy`=0, no `hash_valid`.
- **Reset and ignored inputs:** `reset_n`=0 during DUMP word 4 -> next cycle `busy`=0, `hash_valid`=0. `go` and `host_we` while `busy` are ignored, with memory unchanged.
